// File: rtl/seq_slice_rca.sv
// Multi-cycle ripple-carry adder/subtractor: one SLICE-bit slice per clock, LSB first,
// with the inter-slice carry held in a register and a start/busy/done handshake.
module seq_slice_rca #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_SLICES = WIDTH / SLICE;
    localparam int IDXW       = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE-1:0] a_sl_s;
    logic [SLICE-1:0] b_sl_s;
    logic [SLICE:0]   slice_d;
    logic             msb_cin_d;
    logic [WIDTH-1:0] sum_d;
    logic             last_s;

    // Current slice arithmetic and the merged sum word it produces.
    always_comb begin
        a_sl_s    = a_q[32'(idx_q) * SLICE +: SLICE];
        b_sl_s    = b_q[32'(idx_q) * SLICE +: SLICE];
        slice_d   = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{SLICE{1'b0}}, carry_q};
        // Carry into the slice MSB recovered from the MSB sum bit; valid for any SLICE.
        msb_cin_d = a_sl_s[SLICE-1] ^ b_sl_s[SLICE-1] ^ slice_d[SLICE-1];
        sum_d     = sum_q;
        sum_d[32'(idx_q) * SLICE +: SLICE] = slice_d[SLICE-1:0];
        last_s    = (idx_q == LAST_IDX);
    end

    // Control FSM, operand latches and registered result/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDXW{1'b0}};
            carry_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= {IDXW{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= slice_d[SLICE];
                    idx_q   <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        cout_q  <= slice_d[SLICE];
                        ovf_q   <= msb_cin_d ^ slice_d[SLICE];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_slice_rca.sv
// Bench for seq_slice_rca: three instances (SLICE=4,16,1) checked every cycle against
// an arithmetic reference model, plus directed literal checks from the test plan.
module tb_seq_slice_rca;

    logic        clk = 1'b0;
    logic        rst;
    logic        st [3];
    logic        sb [3];
    logic        ci [3];
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic        bsy [3];
    logic        dn [3];
    logic        co [3];
    logic        ov [3];
    logic [15:0] sm [3];

    // Reference model state: busy cycles left, expected done, held and pending results.
    int          ns [3];
    int          bl [3];
    logic        de [3];
    logic [15:0] hs [3];
    logic [15:0] ps [3];
    logic        hc [3];
    logic        pc [3];
    logic        ho [3];
    logic        po [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_slice_rca #(.WIDTH(16), .SLICE(4)) u_s4 (
        .clk(clk), .rst(rst), .start(st[0]), .sub(sb[0]), .a(av[0]), .b(bv[0]), .cin(ci[0]),
        .busy(bsy[0]), .done(dn[0]), .sum(sm[0]), .cout(co[0]), .ovf(ov[0]));
    seq_slice_rca #(.WIDTH(16), .SLICE(16)) u_s16 (
        .clk(clk), .rst(rst), .start(st[1]), .sub(sb[1]), .a(av[1]), .b(bv[1]), .cin(ci[1]),
        .busy(bsy[1]), .done(dn[1]), .sum(sm[1]), .cout(co[1]), .ovf(ov[1]));
    seq_slice_rca #(.WIDTH(16), .SLICE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(st[2]), .sub(sb[2]), .a(av[2]), .b(bv[2]), .cin(ci[2]),
        .busy(bsy[2]), .done(dn[2]), .sum(sm[2]), .cout(co[2]), .ovf(ov[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            bl[k] = 0; de[k] = 1'b0;
            hs[k] = 16'h0000; hc[k] = 1'b0; ho[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        logic [15:0] bb;
        logic [16:0] r;
        if (bl[k] > 0) begin
            de[k] = (bl[k] == 1);
            if (bl[k] == 1) begin
                hs[k] = ps[k]; hc[k] = pc[k]; ho[k] = po[k];
            end
            bl[k]--;
        end else begin
            de[k] = 1'b0;
            if (st[k]) begin
                bb    = sb[k] ? ~bv[k] : bv[k];
                r     = {1'b0, av[k]} + {1'b0, bb} + ((sb[k] | ci[k]) ? 17'd1 : 17'd0);
                ps[k] = r[15:0];
                pc[k] = r[16];
                po[k] = (av[k][15] == bb[15]) && (r[15] != av[k][15]);
                bl[k] = ns[k];
            end
        end
    endtask

    // One clock: advance the model at the edge, compare every instance at the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else for (int k = 0; k < 3; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(bl[k] > 0));
            chk($sformatf("done[%0d]", k), 32'(dn[k]), 32'(de[k]));
            chk($sformatf("cout[%0d]", k), 32'(co[k]), 32'(hc[k]));
            chk($sformatf("ovf[%0d]", k), 32'(ov[k]), 32'(ho[k]));
            if (bl[k] == 0) chk($sformatf("sum[%0d]", k), 32'(sm[k]), 32'(hs[k]));
        end
    endtask

    task automatic launch(input int k, input logic [15:0] x, input logic [15:0] y,
                          input logic c, input logic s);
        av[k] = x; bv[k] = y; ci[k] = c; sb[k] = s; st[k] = 1'b1;
        cyc();
        st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input bit noise, input string nm);
        int lat;
        lat = 0;
        while (dn[k] !== 1'b1 && lat < 40) begin
            if (noise && lat < 2) begin
                st[k] = 1'b1; av[k] = 16'($urandom_range(0, 65535));
                bv[k] = 16'($urandom_range(0, 65535)); sb[k] = ~sb[k];
            end else begin
                st[k] = 1'b0;
            end
            cyc();
            lat++;
        end
        st[k] = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(ns[k]));
    endtask

    task automatic check_res(input int k, input string nm, input logic [15:0] es,
                             input logic ec, input logic eo);
        chk({nm, "_sum"}, 32'(sm[k]), 32'(es));
        chk({nm, "_cout"}, 32'(co[k]), 32'(ec));
        chk({nm, "_ovf"}, 32'(ov[k]), 32'(eo));
    endtask

    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_busy[%0d]", nm, k), 32'(bsy[k]), 32'd0);
            chk($sformatf("%s_done[%0d]", nm, k), 32'(dn[k]), 32'd0);
            chk($sformatf("%s_sum[%0d]", nm, k), 32'(sm[k]), 32'd0);
            chk($sformatf("%s_cout[%0d]", nm, k), 32'(co[k]), 32'd0);
            chk($sformatf("%s_ovf[%0d]", nm, k), 32'(ov[k]), 32'd0);
        end
        model_reset();
        #1 rst = 1'b0;
    endtask

    logic [15:0] t_a  [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
    logic [15:0] t_b  [5] = '{16'h0FCD, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
    logic        t_c  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        t_s  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] t_es [5] = '{16'h2201, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
    logic        t_ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        t_eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int got [3];
        int c;
        ns[0] = 4; ns[1] = 1; ns[2] = 16;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0; sb[k] = 1'b0; ci[k] = 1'b0; av[k] = 16'h0000; bv[k] = 16'h0000;
        end
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_busy[%0d]", k), 32'(bsy[k]), 32'd0);
            chk($sformatf("reset_done[%0d]", k), 32'(dn[k]), 32'd0);
            chk($sformatf("reset_sum[%0d]", k), 32'(sm[k]), 32'd0);
        end
        rst = 1'b0;
        cyc(); cyc();

        // Directed table on the SLICE=4 instance; the first op also pulses start while busy.
        for (int i = 0; i < 5; i++) begin
            launch(0, t_a[i], t_b[i], t_c[i], t_s[i]);
            wait_done(0, (i == 0), $sformatf("t%0d", i));
            check_res(0, $sformatf("t%0d", i), t_es[i], t_ec[i], t_eo[i]);
            cyc();
        end

        // Start during the done cycle: back-to-back with no idle cycle.
        launch(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
        wait_done(0, 1'b0, "b2b_first");
        check_res(0, "b2b_first", 16'h2201, 1'b0, 1'b0);
        av[0] = 16'h7FFF; bv[0] = 16'h0001; ci[0] = 1'b0; sb[0] = 1'b0; st[0] = 1'b1;
        cyc();
        st[0] = 1'b0;
        chk("b2b_busy", 32'(bsy[0]), 32'd1);
        wait_done(0, 1'b0, "b2b_second");
        check_res(0, "b2b_second", 16'h8000, 1'b0, 1'b1);
        cyc();

        // Asynchronous reset after two RUN cycles; no done may follow.
        launch(0, 16'h1234, 16'h0FCD, 1'b0, 1'b0);
        cyc(); cyc();
        async_reset("midrst");
        repeat (8) cyc();
        launch(0, 16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(0, 1'b0, "post_rst");
        check_res(0, "post_rst", 16'h0002, 1'b0, 1'b0);
        cyc();

        // Slice-width sweep: identical results, latency equal to the slice count.
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                av[k] = t_a[i]; bv[k] = t_b[i]; ci[k] = t_c[i]; sb[k] = t_s[i]; st[k] = 1'b1;
                got[k] = -1;
            end
            cyc();
            for (int k = 0; k < 3; k++) st[k] = 1'b0;
            c = 0;
            while (c < 40 && (got[0] < 0 || got[1] < 0 || got[2] < 0)) begin
                for (int k = 0; k < 3; k++) begin
                    if (dn[k] === 1'b1 && got[k] < 0) begin
                        got[k] = c;
                        check_res(k, $sformatf("sweep%0d_k%0d", i, k), t_es[i], t_ec[i], t_eo[i]);
                    end
                end
                if (got[0] < 0 || got[1] < 0 || got[2] < 0) begin
                    cyc();
                    c++;
                end
            end
            for (int k = 0; k < 3; k++)
                chk($sformatf("sweep%0d_lat%0d", i, k), 32'(got[k]), 32'(ns[k]));
            cyc();
        end

        // Randomised traffic on all instances, including starts while busy and resets.
        for (int n = 0; n < 700; n++) begin
            for (int k = 0; k < 3; k++) begin
                st[k] = ($urandom_range(0, 2) != 0);
                av[k] = 16'($urandom_range(0, 65535));
                bv[k] = 16'($urandom_range(0, 65535));
                if ($urandom_range(0, 7) == 0) av[k] = 16'h7FFF;
                if ($urandom_range(0, 7) == 0) bv[k] = 16'h8000;
                ci[k] = 1'($urandom_range(0, 1));
                sb[k] = 1'($urandom_range(0, 1));
            end
            if (n == 250 || n == 480) async_reset($sformatf("rndrst%0d", n));
            cyc();
        end
        for (int k = 0; k < 3; k++) st[k] = 1'b0;
        repeat (20) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
